// File: rtl/load_store_unit_pkg.sv
// Shared state type, funct3 encodings and byte-enable helper for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, REQ2, WAIT2, DONE} lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Lane mask across two consecutive words: [3:0] first word, [7:4] second word.
  function automatic logic [7:0] be_gen(input logic [2:0] funct3, input logic [1:0] offset);
    logic [7:0] mask;
    case (funct3)
      F3_B, F3_BU: mask = 8'h01;
      F3_H, F3_HU: mask = 8'h03;
      default:     mask = 8'h0F;
    endcase
    return mask << offset;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Load data extraction: shift the (possibly two-word) raw read by the byte
// offset, then sign- or zero-extend according to funct3.
module load_align
  import lsu_pkg::*;
(
  input  logic [63:0] raw_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] word;

  assign word = 32'(raw_i >> {offset_i, 3'b000});

  always_comb begin
    data_o = word;
    case (funct3_i)
      F3_B:    data_o = {{24{word[7]}}, word[7:0]};
      F3_BU:   data_o = {24'h0, word[7:0]};
      F3_H:    data_o = {{16{word[15]}}, word[15:0]};
      F3_HU:   data_o = {16'h0, word[15:0]};
      default: data_o = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit with req/gnt/rvalid data port and pipeline stall.
// Define LSU_SPLIT_MISALIGNED_EN to service misaligned accesses (splitting word-crossing ones).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              LsValid,
  input  logic              MemWrite,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WriteData,
  input  logic [2:0]        Funct3,
  output logic              Stall,
  output logic [31:0]       LoadData,
  output logic              LoadValid,
  output logic              LsFault,
  output logic              DReq,
  output logic              DWe,
  output logic [ADDR_W-1:0] DAddr,
  output logic [3:0]        DBe,
  output logic [31:0]       DWData,
  input  logic              DGnt,
  input  logic              DRValid,
  input  logic [31:0]       DRData
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_TC = CW'(MAX_WAIT - 1);

  lsu_state_t        state_q;
  logic [CW-1:0]     wait_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic              LoadValid_q, LsFault_q, DReq_q, DWe_q;
  logic [31:0]       LoadData_q, DWData_q;
  logic [ADDR_W-1:0] DAddr_q;
  logic [3:0]        DBe_q;

  logic              illegal_d, misal_d, fault_d, wait_tc;
  logic [31:0]       wd_rep_d, ext_d;
  logic [63:0]       raw_d;
`ifdef LSU_SPLIT_MISALIGNED_EN
  logic              split_q;
  logic [3:0]        be_hi_q;
  logic [31:0]       wd_hi_q, lo_q;
  logic              cross_d;
  logic [7:0]        be8_d;
  logic [63:0]       wd_sh_d;
`endif

  always_comb begin
    if (MemWrite) illegal_d = !(Funct3 inside {F3_B, F3_H, F3_W});
    else          illegal_d = !(Funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    case (Funct3)
      F3_H, F3_HU: misal_d = Addr[0];
      F3_W:        misal_d = (Addr[1:0] != 2'b00);
      default:     misal_d = 1'b0;
    endcase
    case (Funct3)
      F3_B:    wd_rep_d = {4{WriteData[7:0]}};
      F3_H:    wd_rep_d = {2{WriteData[15:0]}};
      default: wd_rep_d = WriteData;
    endcase
`ifdef LSU_SPLIT_MISALIGNED_EN
    be8_d   = be_gen(Funct3, Addr[1:0]);
    cross_d = |be8_d[7:4];
    wd_sh_d = {32'h0, WriteData} << {Addr[1:0], 3'b000};
    fault_d = illegal_d;
    raw_d   = (state_q == WAIT2) ? {DRData, lo_q} : {32'h0, DRData};
`else
    fault_d = illegal_d | misal_d;
    raw_d   = {32'h0, DRData};
`endif
  end

  assign wait_tc = (wait_q == WAIT_TC);

  load_align u_align (
    .raw_i    (raw_d),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .data_o   (ext_d)
  );

  // Wait counter is zeroed on every state change; only held-in-place cycles advance it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      off_q       <= '0;
      f3_q        <= '0;
      we_q        <= 1'b0;
      LoadValid_q <= 1'b0;
      LsFault_q   <= 1'b0;
      DReq_q      <= 1'b0;
      DWe_q       <= 1'b0;
      LoadData_q  <= '0;
      DAddr_q     <= '0;
      DBe_q       <= '0;
      DWData_q    <= '0;
`ifdef LSU_SPLIT_MISALIGNED_EN
      split_q     <= 1'b0;
      be_hi_q     <= '0;
      wd_hi_q     <= '0;
      lo_q        <= '0;
`endif
    end else begin
      LoadValid_q <= 1'b0;
      LsFault_q   <= 1'b0;
      wait_q      <= '0;
      case (state_q)
        IDLE: if (LsValid) begin
          off_q <= Addr[1:0];
          f3_q  <= Funct3;
          we_q  <= MemWrite;
          if (fault_d) begin
            state_q   <= DONE;
            LsFault_q <= 1'b1;
          end else begin
            state_q <= REQ;
            DReq_q  <= 1'b1;
            DWe_q   <= MemWrite;
            DAddr_q <= {Addr[ADDR_W-1:2], 2'b00};
`ifdef LSU_SPLIT_MISALIGNED_EN
            split_q  <= cross_d;
            DBe_q    <= be8_d[3:0];
            be_hi_q  <= be8_d[7:4];
            DWData_q <= misal_d ? wd_sh_d[31:0] : wd_rep_d;
            wd_hi_q  <= wd_sh_d[63:32];
`else
            DBe_q    <= 4'(be_gen(Funct3, Addr[1:0]));
            DWData_q <= wd_rep_d;
`endif
          end
        end
        REQ: if (DGnt) begin
          if (!we_q) begin
            state_q <= WAIT;
            DReq_q  <= 1'b0;
          end
`ifdef LSU_SPLIT_MISALIGNED_EN
          else if (split_q) begin
            state_q  <= REQ2;
            DAddr_q  <= DAddr_q + ADDR_W'(4);
            DBe_q    <= be_hi_q;
            DWData_q <= wd_hi_q;
          end
`endif
          else begin
            state_q <= DONE;
            DReq_q  <= 1'b0;
            DWe_q   <= 1'b0;
          end
        end else if (wait_tc) begin
          state_q   <= DONE;
          DReq_q    <= 1'b0;
          DWe_q     <= 1'b0;
          LsFault_q <= 1'b1;
        end else begin
          wait_q <= wait_q + CW'(1);
        end
        WAIT: if (DRValid) begin
`ifdef LSU_SPLIT_MISALIGNED_EN
          if (split_q) begin
            lo_q    <= DRData;
            state_q <= REQ2;
            DReq_q  <= 1'b1;
            DAddr_q <= DAddr_q + ADDR_W'(4);
            DBe_q   <= be_hi_q;
          end else
`endif
          begin
            state_q     <= DONE;
            LoadData_q  <= ext_d;
            LoadValid_q <= 1'b1;
          end
        end else if (wait_tc) begin
          state_q   <= DONE;
          LsFault_q <= 1'b1;
        end else begin
          wait_q <= wait_q + CW'(1);
        end
`ifdef LSU_SPLIT_MISALIGNED_EN
        REQ2: if (DGnt) begin
          state_q <= we_q ? DONE : WAIT2;
          DReq_q  <= 1'b0;
          DWe_q   <= 1'b0;
        end else if (wait_tc) begin
          state_q   <= DONE;
          DReq_q    <= 1'b0;
          DWe_q     <= 1'b0;
          LsFault_q <= 1'b1;
        end else begin
          wait_q <= wait_q + CW'(1);
        end
        WAIT2: if (DRValid) begin
          state_q     <= DONE;
          LoadData_q  <= ext_d;
          LoadValid_q <= 1'b1;
        end else if (wait_tc) begin
          state_q   <= DONE;
          LsFault_q <= 1'b1;
        end else begin
          wait_q <= wait_q + CW'(1);
        end
`endif
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Stall     = (state_q == IDLE) ? LsValid : (state_q != DONE);
  assign LoadData  = LoadData_q;
  assign LoadValid = LoadValid_q;
  assign LsFault   = LsFault_q;
  assign DReq      = DReq_q;
  assign DWe       = DWe_q;
  assign DAddr     = DAddr_q;
  assign DBe       = DBe_q;
  assign DWData    = DWData_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random accesses
// compared against a byte-level reference model of the memory access rules.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        LsValid = 1'b0, MemWrite = 1'b0;
  logic [31:0] Addr = '0, WriteData = '0;
  logic [2:0]  Funct3 = '0;
  logic        Stall, LoadValid, LsFault, DReq, DWe;
  logic [31:0] LoadData, DWData, DAddr;
  logic [3:0]  DBe;
  logic        DGnt = 1'b0, DRValid = 1'b0;
  logic [31:0] DRData = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .LsValid(LsValid), .MemWrite(MemWrite), .Addr(Addr),
    .WriteData(WriteData), .Funct3(Funct3), .Stall(Stall), .LoadData(LoadData),
    .LoadValid(LoadValid), .LsFault(LsFault), .DReq(DReq), .DWe(DWe), .DAddr(DAddr),
    .DBe(DBe), .DWData(DWData), .DGnt(DGnt), .DRValid(DRValid), .DRData(DRData)
  );

  // observations of one access
  logic [31:0] q_addr[$], q_wd[$];
  logic [3:0]  q_be[$];
  logic        q_we[$];
  int          obs_stall, obs_done, lv_pulses, flt_pulses, req_cycles;
  logic [31:0] obs_ld;
  logic        obs_dreq_done, timed_out, post_busy;

  // reference expectations
  logic        e_fault;
  int          e_nreq, e_stall;
  logic [31:0] e_addr[2], e_wd[2], e_mask[2];
  logic [3:0]  e_be[2];
  logic [31:0] e_ld, last_ld = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input logic [31:0] rd0, input logic [31:0] rd1,
                        input int gd, input int rdl, input logic stray);
    int gcnt, rcnt, resp_idx;
    logic awaiting, new_req;
    q_addr.delete(); q_wd.delete(); q_be.delete(); q_we.delete();
    obs_stall = 0; obs_done = 0; lv_pulses = 0; flt_pulses = 0; req_cycles = 0;
    timed_out = 1'b1; obs_dreq_done = 1'b0; obs_ld = 'x;
    gcnt = gd; rcnt = 0; resp_idx = 0; awaiting = 1'b0; new_req = 1'b1;
    @(negedge clk);
    LsValid = 1'b1; MemWrite = we; Addr = addr; WriteData = wd; Funct3 = f3;
    for (int c = 1; c <= 600; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      if (Stall) obs_stall++;
      if (LoadValid) lv_pulses++;
      if (LsFault) flt_pulses++;
      if (DReq) req_cycles++;
      if (!Stall) begin
        obs_ld = LoadData; obs_done = c; obs_dreq_done = DReq; timed_out = 1'b0;
        break;
      end
      if (awaiting) begin
        if (rcnt == 0) begin
          DRValid = 1'b1; DRData = (resp_idx == 0) ? rd0 : rd1;
          resp_idx++; awaiting = 1'b0;
        end else begin
          DRValid = 1'b0; rcnt--;
        end
        DGnt = stray;
      end else if (DReq) begin
        if (new_req) begin
          q_addr.push_back(DAddr); q_be.push_back(DBe);
          q_wd.push_back(DWData); q_we.push_back(DWe);
          new_req = 1'b0;
        end
        DRValid = stray; DRData = $urandom;
        if (gcnt == 0) begin
          DGnt = 1'b1; new_req = 1'b1; gcnt = gd;
          if (!DWe) begin awaiting = 1'b1; rcnt = rdl; end
        end else begin
          DGnt = 1'b0; gcnt--;
        end
      end else begin
        DGnt = stray; DRValid = stray; DRData = $urandom;
      end
    end
    LsValid = 1'b0; DGnt = 1'b0; DRValid = 1'b0;
    @(negedge clk);
    #1;
    post_busy = Stall | LoadValid | LsFault | DReq;
  endtask

  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, input logic [31:0] rd0, input logic [31:0] rd1,
                       input int gd, input int rdl);
    int size, off;
    logic legal, sgn;
    longint val;
    logic [31:0] rw[2];
    rw[0] = rd0; rw[1] = rd1;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      default:    size = 4;
    endcase
    sgn   = (f3 == 3'd0) || (f3 == 3'd1);
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    off   = int'(addr % 4);
    e_fault = !legal;
`ifndef LSU_SPLIT_MISALIGNED_EN
    if (off % size != 0) e_fault = 1'b1;
`endif
    e_nreq = 0; val = 0;
    for (int k = 0; k < 2; k++) begin
      e_addr[k] = (addr & ~32'h3) + 32'(4 * k);
      e_be[k] = '0; e_wd[k] = '0; e_mask[k] = '0;
    end
    if (!e_fault) begin
      for (int i = 0; i < size; i++) begin
        int idx, lane;
        idx  = (off + i) / 4;
        lane = (off + i) % 4;
        e_be[idx][lane] = 1'b1;
        e_mask[idx][8*lane +: 8] = 8'hFF;
        e_wd[idx][8*lane +: 8] = wd[8*i +: 8];
        val = val | (longint'((rw[idx] >> (8 * lane)) & 32'hFF) << (8 * i));
        if (idx + 1 > e_nreq) e_nreq = idx + 1;
      end
      if (off % size == 0) begin
        e_mask[0] = '1;
        for (int j = 0; j < 4; j++) e_wd[0][8*j +: 8] = wd[8*(j % size) +: 8];
      end
      if (sgn && val[8*size-1]) val = val | ~((longint'(1) << (8 * size)) - 1);
    end
    e_ld    = (!we && !e_fault) ? val[31:0] : last_ld;
    e_stall = e_fault ? 1 : 1 + e_nreq * (gd + 1) + (we ? 0 : e_nreq * (rdl + 1));
  endtask

  task automatic verify(input string tag, input logic we);
    check({tag, ".bound"}, 64'(timed_out), 64'(0));
    check({tag, ".stall"}, 64'(obs_stall), 64'(e_stall));
    check({tag, ".done"}, 64'(obs_done), 64'(e_stall + 1));
    check({tag, ".lv"}, 64'(lv_pulses), 64'((!we && !e_fault) ? 1 : 0));
    check({tag, ".fault"}, 64'(flt_pulses), 64'(e_fault ? 1 : 0));
    check({tag, ".ld"}, 64'(obs_ld), 64'(e_ld));
    check({tag, ".dreq_done"}, 64'(obs_dreq_done), 64'(0));
    check({tag, ".post"}, 64'(post_busy), 64'(0));
    check({tag, ".nreq"}, 64'(q_addr.size()), 64'(e_nreq));
    for (int i = 0; i < e_nreq && i < q_addr.size(); i++) begin
      check($sformatf("%s.addr%0d", tag, i), 64'(q_addr[i]), 64'(e_addr[i]));
      check($sformatf("%s.be%0d", tag, i), 64'(q_be[i]), 64'(e_be[i]));
      check($sformatf("%s.we%0d", tag, i), 64'(q_we[i]), 64'(we));
      if (we) check($sformatf("%s.wd%0d", tag, i), 64'(q_wd[i] & e_mask[i]), 64'(e_wd[i] & e_mask[i]));
    end
    last_ld = e_ld;
  endtask

  task automatic op(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                    input logic [2:0] f3, input logic [31:0] rd0, input logic [31:0] rd1,
                    input int gd, input int rdl, input logic stray);
    model(we, addr, wd, f3, rd0, rd1, gd, rdl);
    run_op(we, addr, wd, f3, rd0, rd1, gd, rdl, stray);
    verify(tag, we);
  endtask

  initial begin
    logic        lv_seen;
    logic        r_we, r_stray;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset.stall", 64'(Stall), 64'(0));
    check("reset.lv", 64'(LoadValid), 64'(0));
    check("reset.fault", 64'(LsFault), 64'(0));
    check("reset.dreq", 64'(DReq), 64'(0));
    check("reset.dwe", 64'(DWe), 64'(0));
    check("reset.outs", {LoadData, DWData}, 64'(0));
    check("reset.daddr", 64'(DAddr), 64'(0));
    check("reset.dbe", 64'(DBe), 64'(0));

    op("lw100", 1'b0, 32'h100, 32'h0, 3'b010, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0);
    check("lw100.cycle4", 64'(obs_done), 64'(4));
    check("lw100.data", 64'(obs_ld), 64'(32'hDEADBEEF));
    check("lw100.dbe", 64'((q_be.size() > 0) ? q_be[0] : 4'hx), 64'(4'b1111));

    op("lb203", 1'b0, 32'h203, 32'h0, 3'b000, 32'h80FF_FFFF, 32'h0, 0, 0, 1'b0);
    check("lb203.dbe", 64'((q_be.size() > 0) ? q_be[0] : 4'hx), 64'(4'b1000));
    check("lb203.data", 64'(obs_ld), 64'(32'hFFFFFF80));
    op("lbu203", 1'b0, 32'h203, 32'h0, 3'b100, 32'h80FF_FFFF, 32'h0, 0, 0, 1'b0);
    check("lbu203.data", 64'(obs_ld), 64'(32'h00000080));

    op("sh302", 1'b1, 32'h302, 32'h1234ABCD, 3'b001, 32'h0, 32'h0, 1, 0, 1'b1);
    check("sh302.dwdata", 64'((q_wd.size() > 0) ? q_wd[0] : 32'hx), 64'(32'hABCDABCD));
    check("sh302.dbe", 64'((q_be.size() > 0) ? q_be[0] : 4'hx), 64'(4'b1100));
    check("sh302.nolv", 64'(lv_pulses), 64'(0));

    op("lw101", 1'b0, 32'h101, 32'h0, 3'b010, 32'h44332211, 32'h88776655, 0, 0, 1'b0);
`ifdef LSU_SPLIT_MISALIGNED_EN
    check("lw101.data", 64'(obs_ld), 64'(32'h55443322));
    check("lw101.addr1", 64'((q_addr.size() > 1) ? q_addr[1] : 32'hx), 64'(32'h104));
`else
    check("lw101.fault", 64'(flt_pulses), 64'(1));
    check("lw101.noreq", 64'(req_cycles), 64'(0));
`endif

    // grant withheld: bus timeout
    run_op(1'b0, 32'h400, 32'h0, 3'b010, 32'h0, 32'h0, 1000, 0, 1'b0);
    check("tmo.bound", 64'(timed_out), 64'(0));
    check("tmo.fault", 64'(flt_pulses), 64'(1));
    check("tmo.nolv", 64'(lv_pulses), 64'(0));
    check("tmo.reqcyc", 64'(req_cycles), 64'(255));
    check("tmo.stall", 64'(obs_stall), 64'(256));
    check("tmo.dreq_done", 64'(obs_dreq_done), 64'(0));
    check("tmo.ld", 64'(obs_ld), 64'(last_ld));
    check("tmo.post", 64'(post_busy), 64'(0));

    // reset while waiting for read data
    @(negedge clk);
    LsValid = 1'b1; MemWrite = 1'b0; Addr = 32'h500; Funct3 = 3'b010;
    @(negedge clk);
    check("rst.req", 64'(DReq), 64'(1));
    DGnt = 1'b1;
    @(negedge clk);
    check("rst.wait", 64'(DReq), 64'(0));
    DGnt = 1'b0; rst = 1'b1; LsValid = 1'b0;
    @(negedge clk);
    lv_seen = LoadValid;
    rst = 1'b0; DRValid = 1'b1; DRData = 32'hCAFEF00D;
    @(negedge clk);
    lv_seen = lv_seen | LoadValid;
    DRValid = 1'b0;
    check("rst.ctl", {60'h0, Stall, LsFault, DReq, DWe}, 64'(0));
    check("rst.data", {LoadData, DWData}, 64'(0));
    check("rst.addr_be", {28'h0, DAddr, DBe}, 64'(0));
    @(negedge clk);
    lv_seen = lv_seen | LoadValid;
    check("rst.nolv", 64'(lv_seen), 64'(0));
    last_ld = '0;

    for (int n = 0; n < 60; n++) begin
      r_we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: r_f3 = 3'd0;
        1: r_f3 = 3'd1;
        2: r_f3 = 3'd2;
        3: r_f3 = 3'd4;
        4: r_f3 = 3'd5;
        default: r_f3 = 3'($urandom_range(0, 7));
      endcase
      r_addr = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        if (r_f3 == 3'd2) r_addr[1:0] = 2'b00;
        else if (r_f3 == 3'd1 || r_f3 == 3'd5) r_addr[0] = 1'b0;
      end
      r_stray = 1'($urandom_range(0, 1));
      op($sformatf("rnd%0d", n), r_we, r_addr, $urandom, r_f3, $urandom, $urandom,
         $urandom_range(0, 3), $urandom_range(0, 3), r_stray);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
